// File: rtl/user_input_debounce.sv
// Switch and push-button conditioner: 2-flop sync, per-channel debounce,
// registered mode word with change pulse and a press-pulse button FSM.
module user_input_debounce #(
    parameter  int DEBOUNCE_CYCLES = 1000000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_in,
    input  logic       btn_in,
    output logic [3:0] state,
    output logic       state_changed,
    output logic       btn_level,
    output logic       btn_pulse
);

    localparam int                 NCH     = 5;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_RELEASED,
        ST_PRESSED
    } btn_st_t;

    logic [NCH-1:0]   r_sync1;
    logic [NCH-1:0]   r_sync2;
    logic [NCH-1:0]   r_stable;
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [3:0]       r_state_d;
    logic             r_changed;
    logic             r_btn_pulse;
    btn_st_t          r_btn_st;
    btn_st_t          w_btn_st_nxt;
    logic             w_pulse_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btn_in, sw_in};
            r_sync2 <= r_sync1;
        end
    end

    // Channel 4 is the button; channels 3..0 are the mode switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_d <= '0;
            r_changed <= 1'b0;
        end else begin
            r_state_d <= r_stable[3:0];
            r_changed <= |(r_stable[3:0] ^ r_state_d);
        end
    end

    always_comb begin
        w_btn_st_nxt = r_btn_st;
        w_pulse_nxt  = 1'b0;
        case (r_btn_st)
            ST_RELEASED: begin
                if (r_stable[4]) begin
                    w_btn_st_nxt = ST_PRESSED;
                    w_pulse_nxt  = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!r_stable[4]) begin
                    w_btn_st_nxt = ST_RELEASED;
                end
            end
            default: w_btn_st_nxt = ST_RELEASED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_st    <= ST_RELEASED;
            r_btn_pulse <= 1'b0;
        end else begin
            r_btn_st    <= w_btn_st_nxt;
            r_btn_pulse <= w_pulse_nxt;
        end
    end

    assign state         = r_stable[3:0];
    assign state_changed = r_changed;
    assign btn_level     = r_stable[4];
    assign btn_pulse     = r_btn_pulse;

endmodule
